// File: rtl/sha256_pkg.sv
// sha256_pkg: constants and types shared by the SHA-256 front end.
//   BLOCK_BYTES / LEN_POS / PAD_BYTE : block geometry and padding marker
//   pad_state_t                      : padder FSM encoding
//   pad_kind_t                       : deferred extra-block padding kind
//   block_t / len_field_t            : byte-addressable block and length field
package sha256_pkg;

  localparam int unsigned BLOCK_BYTES = 64;
  localparam int unsigned BLOCK_BITS  = BLOCK_BYTES * 8;
  localparam int unsigned LEN_POS     = 56;
  localparam int unsigned LEN_BYTES   = BLOCK_BYTES - LEN_POS;
  localparam int unsigned IDX_W       = 6;
  localparam int unsigned MLEN_W      = 61;
  localparam logic [7:0]  PAD_BYTE    = 8'h80;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_ISSUE,
    ST_HOLD,
    ST_BUSY,
    ST_PADX
  } pad_state_t;

  typedef enum logic [1:0] {
    PAD_NONE,
    PAD_ZERO,
    PAD_80
  } pad_kind_t;

  // Lane 63 is the most significant byte, so message byte 0 lands in [511:504].
  typedef logic [BLOCK_BYTES-1:0][7:0] block_t;
  typedef logic [LEN_BYTES-1:0][7:0]   len_field_t;

  // Message byte index -> packed lane (63 - idx).
  function automatic logic [IDX_W-1:0] lane(input logic [IDX_W-1:0] idx);
    return ~idx;
  endfunction

  // Big-endian 64-bit bit count of a byte length; occupies lanes 7..0.
  function automatic len_field_t len_field(input logic [MLEN_W-1:0] nbytes);
    return {nbytes, 3'b000};
  endfunction

endpackage

// File: rtl/sha256_padder.sv
// sha256_padder: byte-stream front end for sha256_core.
// Collects one byte per cycle into a 512-bit block, applies message padding
// and the 64-bit length, and sequences init/next pulses to the core.
// Ports:
//   clk, reset_n         : clock, async active-low reset
//   mode                 : digest select, latched with a message's first byte
//   s_data/s_valid/s_last/s_ready : byte stream input (valid/ready)
//   core_ready           : core idle indication
//   core_init/core_next  : one-cycle block start pulses
//   core_block/core_mode : block and latched mode presented to the core
//   msg_done             : one-cycle pulse when the final block is absorbed
module sha256_padder
  import sha256_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mode,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  core_ready,
  output logic                  core_init,
  output logic                  core_next,
  output logic [BLOCK_BITS-1:0] core_block,
  output logic                  core_mode,
  output logic                  msg_done
);

  pad_state_t        r_state;
  logic [IDX_W-1:0]  r_k;
  logic [MLEN_W-1:0] r_msg_len;
  logic              r_first;
  logic              r_final;
  pad_kind_t         r_pad;
  block_t            r_block;
  logic              r_mode;

  logic              w_accept;
  logic              w_issue;
  logic [IDX_W:0]    w_n;
  logic [MLEN_W-1:0] w_len_inc;
  block_t            w_last_blk;
  block_t            w_padx_blk;

  assign w_accept  = s_valid && (r_state == ST_FILL);
  assign w_issue   = (r_state == ST_ISSUE) && core_ready;
  assign w_n       = {1'b0, r_k} + (IDX_W+1)'(1);
  assign w_len_inc = r_msg_len + MLEN_W'(1);

  // Handshake and pulse outputs are decoded from state so that each pulse
  // lands in the same cycle the core reports ready; HOLD relies on this.
  assign s_ready    = reset_n && (r_state == ST_FILL);
  assign core_init  = w_issue && r_first;
  assign core_next  = w_issue && !r_first;
  assign msg_done   = (r_state == ST_BUSY) && core_ready && r_final;
  assign core_block = r_block;
  assign core_mode  = r_mode;

  // Block as it should look once the last message byte is written at k.
  always_comb begin
    w_last_blk = r_block;
    w_last_blk[lane(r_k)] = s_data;
    for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
      if ((IDX_W+1)'(i) > {1'b0, r_k}) begin
        w_last_blk[lane(IDX_W'(i))] = ((IDX_W+1)'(i) == w_n) ? PAD_BYTE : 8'h00;
      end
    end
    // Length only fits when the 0x80 marker sits below the length field.
    if (w_n < (IDX_W+1)'(LEN_POS)) begin
      w_last_blk[LEN_BYTES-1:0] = len_field(w_len_inc);
    end
  end

  // Extra block when padding spills past the current one.
  always_comb begin
    w_padx_blk = '0;
    if (r_pad == PAD_80) begin
      w_padx_blk[lane(IDX_W'(0))] = PAD_BYTE;
    end
    w_padx_blk[LEN_BYTES-1:0] = len_field(r_msg_len);
  end

  // Padder sequencing: fill, issue to core, wait, optional extra pad block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_FILL;
      r_k       <= '0;
      r_msg_len <= '0;
      r_first   <= 1'b1;
      r_final   <= 1'b0;
      r_pad     <= PAD_NONE;
      r_block   <= '0;
      r_mode    <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            // A zero length counter means this is the message's first byte.
            if (r_msg_len == '0) begin
              r_mode <= mode;
            end
            r_msg_len <= w_len_inc;
            if (s_last) begin
              r_block <= w_last_blk;
              r_k     <= '0;
              r_state <= ST_ISSUE;
              if (w_n < (IDX_W+1)'(LEN_POS)) begin
                r_final <= 1'b1;
                r_pad   <= PAD_NONE;
              end else if (w_n < (IDX_W+1)'(BLOCK_BYTES)) begin
                r_final <= 1'b0;
                r_pad   <= PAD_ZERO;
              end else begin
                r_final <= 1'b0;
                r_pad   <= PAD_80;
              end
            end else begin
              r_block[lane(r_k)] <= s_data;
              r_k                <= r_k + IDX_W'(1);
              if (r_k == IDX_W'(BLOCK_BYTES - 1)) begin
                r_final <= 1'b0;
                r_pad   <= PAD_NONE;
                r_state <= ST_ISSUE;
              end
            end
          end
        end

        ST_ISSUE: begin
          if (core_ready) begin
            r_first <= 1'b0;
            r_state <= ST_HOLD;
          end
        end

        // Core still shows ready for one cycle after accepting a block.
        ST_HOLD: begin
          r_state <= ST_BUSY;
        end

        ST_BUSY: begin
          if (core_ready) begin
            if (r_final) begin
              r_msg_len <= '0;
              r_first   <= 1'b1;
              r_final   <= 1'b0;
              r_pad     <= PAD_NONE;
              r_block   <= '0;
              r_k       <= '0;
              r_state   <= ST_FILL;
            end else if (r_pad != PAD_NONE) begin
              r_state <= ST_PADX;
            end else begin
              r_block <= '0;
              r_k     <= '0;
              r_state <= ST_FILL;
            end
          end
        end

        ST_PADX: begin
          r_block <= w_padx_blk;
          r_pad   <= PAD_NONE;
          r_final <= 1'b1;
          r_state <= ST_ISSUE;
        end

        default: begin
          r_state <= ST_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: self-checking bench for sha256_padder.
// A reference model pads each message with plain queue arithmetic and the
// issued blocks, init/next flags and latched mode are compared against it.
// A small core model drops ready one cycle after a start pulse.
module tb_sha256_padder;

  typedef logic [7:0] byte_q_t[$];

  logic         clk = 1'b0;
  logic         reset_n;
  logic         mode;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic         core_ready;
  logic         core_init;
  logic         core_next;
  logic [511:0] core_block;
  logic         core_mode;
  logic         msg_done;

  int n_checks = 0;
  int n_errs   = 0;
  int done_cnt = 0;

  logic [511:0] obs_blk[$];
  logic         obs_init[$];
  logic         obs_mode[$];
  logic [511:0] exp_blk[$];

  logic rdy_q;
  logic force_low;
  logic core_delay;
  int   busy_cnt;

  always #5 clk = ~clk;

  sha256_padder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode       (mode),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .core_ready (core_ready),
    .core_init  (core_init),
    .core_next  (core_next),
    .core_block (core_block),
    .core_mode  (core_mode),
    .msg_done   (msg_done)
  );

  assign core_ready = rdy_q & ~force_low;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Core model: stays ready one cycle after a start, then busy 1..8 cycles.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q      <= 1'b1;
      core_delay <= 1'b0;
      busy_cnt   <= 0;
    end else if ((core_init || core_next) && core_ready) begin
      core_delay <= 1'b1;
    end else if (core_delay) begin
      core_delay <= 1'b0;
      rdy_q      <= 1'b0;
      busy_cnt   <= int'($urandom_range(1, 8));
    end else if (!rdy_q) begin
      if (busy_cnt <= 1) rdy_q <= 1'b1;
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Capture every issued block and count completion pulses.
  always @(negedge clk) begin
    if (reset_n) begin
      if (core_init || core_next) begin
        chk("pulse_needs_ready", 512'(core_ready), 512'd1);
        chk("init_xor_next", 512'(core_init & core_next), 512'd0);
        obs_blk.push_back(core_block);
        obs_init.push_back(core_init);
        obs_mode.push_back(core_mode);
      end
      if (msg_done) done_cnt++;
    end
  end

  function automatic byte_q_t str2q(input string s);
    byte_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference padding: msg, 0x80, zeros to 56 mod 64, 64-bit bit length.
  task automatic build_exp(input byte_q_t m);
    byte_q_t      p;
    logic [63:0]  bits;
    logic [511:0] blk;
    p = m;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bits = 64'(m.size()) * 64'd8;
    for (int j = 0; j < 8; j++) p.push_back(8'(bits >> (56 - 8 * j)));
    exp_blk.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) blk = {blk[503:0], p[b * 64 + i]};
      exp_blk.push_back(blk);
    end
  endtask

  // gap_mode: 0 none, 1 idle cycle before every byte, 2 random idles.
  task automatic send_msg(input byte_q_t m, input logic md, input int gap_mode, input bit hold);
    int cyc;
    int d0;
    bit ok;
    obs_blk.delete();
    obs_init.delete();
    obs_mode.delete();
    build_exp(m);
    d0 = done_cnt;
    force_low = hold;
    for (int i = 0; i < m.size(); i++) begin
      int gaps;
      gaps = (gap_mode == 1) ? 1 : ((gap_mode == 2) ? int'($urandom_range(0, 2)) : 0);
      repeat (gaps) begin
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'($urandom);
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = m[i];
      s_last  = (i == m.size() - 1);
      mode    = (i == 0) ? md : ~md;
      cyc = 0;
      while (!s_ready && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      if (!s_ready) begin
        chk("stall_timeout", 512'd0, 512'd1);
        s_valid = 1'b0;
        force_low = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("s_ready_low_after_last", 512'(s_ready), 512'd0);
    if (hold) begin
      repeat (20) @(negedge clk);
      chk("no_issue_while_low", 512'(obs_blk.size()), 512'd0);
      force_low = 1'b0;
    end
    ok = 1'b0;
    for (cyc = 0; cyc < 3000 && !ok; cyc++) begin
      @(negedge clk);
      if (msg_done) begin
        ok = 1'b1;
        chk("s_ready_in_done_cycle", 512'(s_ready), 512'd0);
      end
    end
    chk("msg_done_seen", 512'(ok), 512'd1);
    if (ok) begin
      @(negedge clk);
      chk("s_ready_after_done", 512'(s_ready), 512'd1);
    end
    repeat (3) @(negedge clk);
    chk("msg_done_count", 512'(done_cnt - d0), 512'd1);
    chk("n_blocks", 512'(obs_blk.size()), 512'(exp_blk.size()));
    for (int b = 0; b < exp_blk.size() && b < obs_blk.size(); b++) begin
      chk($sformatf("block%0d_len%0d", b, m.size()), obs_blk[b], exp_blk[b]);
      chk("init_vs_next", 512'(obs_init[b]), 512'(b == 0));
      chk("core_mode", 512'(obs_mode[b]), 512'(md));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte_q_t m;
    int lens[12] = '{1, 55, 56, 57, 63, 64, 65, 119, 120, 127, 128, 129};

    reset_n   = 1'b0;
    mode      = 1'b0;
    s_data    = 8'h00;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    force_low = 1'b0;
    #2;
    chk("rst_s_ready", 512'(s_ready), 512'd0);
    chk("rst_core_init", 512'(core_init), 512'd0);
    chk("rst_core_next", 512'(core_next), 512'd0);
    chk("rst_msg_done", 512'(msg_done), 512'd0);
    chk("rst_core_block", core_block, 512'd0);
    chk("rst_core_mode", 512'(core_mode), 512'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", 512'(s_ready), 512'd1);

    // "abc" in both modes
    send_msg(str2q("abc"), 1'b0, 0, 1'b0);
    chk("abc_block_const", obs_blk[0], {32'h61626380, 416'h0, 64'h18});
    send_msg(str2q("abc"), 1'b1, 0, 1'b0);

    // 56-byte message: length spills into a second, otherwise zero block
    send_msg(str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), 1'b1, 0, 1'b0);
    chk("b56_second_const", obs_blk[1], {448'h0, 64'h1c0});

    // 64 x 'a': second block starts with the 0x80 marker
    m.delete();
    repeat (64) m.push_back(8'h61);
    send_msg(m, 1'b0, 0, 1'b0);
    chk("b64_second_const", obs_blk[1], {8'h80, 440'h0, 64'h200});

    // toggling valid plus core_ready held low while the block waits
    send_msg(str2q("abc"), 1'b0, 1, 1'b1);
    chk("abc_gap_const", obs_blk[0], {32'h61626380, 416'h0, 64'h18});

    // reset in the middle of a message
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      s_last  = 1'b0;
      mode    = 1'b1;
    end
    @(negedge clk);
    s_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_s_ready", 512'(s_ready), 512'd0);
    chk("midrst_core_block", core_block, 512'd0);
    chk("midrst_core_mode", 512'(core_mode), 512'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_s_ready_back", 512'(s_ready), 512'd1);
    send_msg(str2q("abc"), 1'b0, 0, 1'b0);
    chk("midrst_abc_const", obs_blk[0], {32'h61626380, 416'h0, 64'h18});

    // boundary lengths and random lengths with random data, gaps and mode
    for (int t = 0; t < 18; t++) begin
      int len;
      len = (t < 12) ? lens[t] : int'($urandom_range(1, 200));
      m.delete();
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      send_msg(m, 1'($urandom), 2, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
# sha256_padder

Byte-stream front end for `sha256_core`. Accepts a message one byte per cycle on a valid/ready interface and assembles 512-bit blocks, applying FIPS 180-4 padding and the 64-bit big-endian bit length. It drives the core's `init`/`next`/`block`/`mode` inputs directly, sequences multi-block messages, and signals when the final block has been absorbed.

## Interface
- No parameters. Block size and padding constants come from the shared package.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mode`  in  1  digest select for the core (0 = SHA-224, 1 = SHA-256). Sampled with the first byte of each message.
- `s_data`  in  8  message byte.
- `s_valid`  in  1  `s_data` valid.
- `s_last`  in  1  marks the final byte of the message; qualified by `s_valid`.
- `s_ready`  out  1  padder can accept a byte this cycle.
- `core_ready`  in  1  `sha256_core` ready.
- `core_init`  out  1  one-cycle pulse that starts the first block of a message.
- `core_next`  out  1  one-cycle pulse that starts each subsequent block.
- `core_block`  out  512  block presented to the core; byte 0 occupies bits [511:504].
- `core_mode`  out  1  latched `mode`, held for the whole message.
- `msg_done`  out  1  one-cycle pulse when the core returns ready after the final block.

## Operation
- States:
  - FILL: accepting bytes.
  - ISSUE: waiting for `core_ready` = 1, then pulsing init or next.
  - HOLD: one cycle with `core_ready` ignored.
  - BUSY: waiting for `core_ready` = 1.
  - PADX: building the extra padding block.
- Byte index `k` (0..63) addresses positions in the current block. `msg_len` is a 61-bit byte counter; the length field is `{msg_len, 3'b000}` placed in bytes 56..63.
- `first` flag is set at message start and selects `core_init` over `core_next`. It clears after the first issue.
- FILL, accepted byte without `s_last`:
  - Write the byte at `k`, then increment `k` and `msg_len`.
  - When `k` reaches 64, go to ISSUE with `final` = 0.
- FILL, accepted byte with `s_last`: let `n` = bytes now in the block (1..64).
  - `n` ≤ 55: write 0x80 at `n`, zeros in `n+1`..55, length in 56..63. Go to ISSUE with `final` = 1.
  - 56 ≤ `n` ≤ 63: write 0x80 at `n` and zeros to byte 63. Go to ISSUE with `final` = 0 and `pad_pending` = PAD_ZERO.
  - `n` = 64: go to ISSUE with `final` = 0 and `pad_pending` = PAD_80.
- After BUSY on a non-final block:
  - `pad_pending` set: PADX builds the extra block (0x80 at byte 0 if PAD_80, else zero; zeros to byte 55; length in 56..63). Then ISSUE with `final` = 1.
  - Otherwise: clear the block buffer, reset `k` to 0, return to FILL.
- After BUSY on the final block: pulse `msg_done`, clear `msg_len`, `first` and the buffer, return to FILL.
- `s_ready` = 1 only in FILL. `core_block` is stable from ISSUE until BUSY exits.
- Messages are at least 1 byte long; empty messages are unsupported.
- `mode` is latched when a message's first byte is accepted.

## Timing
- Reset values:
  - State FILL, `k` = 0, `msg_len` = 0, `first` = 1.
  - `s_ready` = 1 (0 while `reset_n` is low).
  - `core_init`, `core_next`, `msg_done`, `core_mode` = 0; `core_block` = 0.
- Throughput: one byte per cycle in FILL. A 64-byte block takes 64 accepted cycles, then ISSUE.
- ISSUE: `core_init` or `core_next` is high for exactly one cycle, the first cycle in ISSUE with `core_ready` = 1. The next state is HOLD.
- HOLD absorbs the core's one-cycle delay in dropping ready. BUSY then exits on the first cycle with `core_ready` = 1.
- `msg_done` is asserted in that exit cycle for the final block. `s_ready` rises the following cycle.
- `s_valid` with `s_ready` = 0 is stalled and has no effect. Gaps in `s_valid` are allowed anywhere.
- `reset_n` asserted mid-message aborts immediately. No pulse is emitted and the partial block is discarded.

## Structure
- `sha256_pkg` holds:
  - BLOCK_BYTES = 64, LEN_POS = 56, PAD_BYTE = 8'h80;
  - the padder state encoding;
  - the PAD_NONE/PAD_ZERO/PAD_80 encoding.
- No sub-module. Block storage is one 512-bit register with a byte-lane write at `k`.
- The integration wrapper `sha256_stream` instantiates `sha256_padder` and `sha256_core`, and is the unit under test.

## Test plan
- "abc", `mode` = 0 → one `core_init`; `core_block` = 616263 80, zeros, ...0018. Digest 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 d2da082d. One `msg_done`.
- "abc", `mode` = 1 → same block; digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- 56-byte "abcdbcdecdef…nopq", `mode` = 1 → `core_init` then `core_next`. The second block is all zero except length ...01c0. Digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- 64 bytes of 0x61 → two blocks. The second block starts with 0x80 and has length ...0200. Exactly one `msg_done`.
- "abc" with `s_valid` toggling every other cycle, and `core_ready` forced low 20 cycles at ISSUE → identical block and digest. No pulse while `core_ready` is low.
- Reset asserted after 10 bytes, then "abc" sent → `core_init` only for "abc", with correct length 0x18.
